// File: rtl/chunked_adder.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock and keeps the
// inter-chunk carry in a register, with valid/ready on both sides.
module chunked_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    // state | meaning
    // IDLE  | waiting for in_valid, in_ready=1
    // BUSY  | adding one chunk per edge, LSB chunk first
    // DONE  | result held until out_ready
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int BW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry_r;
    logic [CW-1:0]    rem;
    logic [CW-1:0]    idx;
    logic [BW-1:0]    base;
    logic [CHUNK-1:0] a_c;
    logic [CHUNK-1:0] b_c;
    logic [CHUNK-1:0] s_c;
    logic             c_out;
    logic             c_msb;

    // rem counts down to the final chunk; idx walks chunks upward from the LSB
    always_comb begin
        idx  = CW'(NCHUNK - 1) - rem;
        base = BW'(int'(idx) * CHUNK);
        a_c  = a_r[base +: CHUNK];
        b_c  = b_r[base +: CHUNK];
        {c_out, s_c} = {1'b0, a_c} + {1'b0, b_c} + {{CHUNK{1'b0}}, carry_r};
        // carry into the chunk MSB, recovered from the sum bit
        c_msb = a_c[CHUNK-1] ^ b_c[CHUNK-1] ^ s_c[CHUNK-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            carry_r   <= 1'b0;
            rem       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r      <= op_a;
                        b_r      <= op_b ^ {WIDTH{sub}};
                        carry_r  <= sub | cin;
                        rem      <= CW'(NCHUNK - 1);
                        in_ready <= 1'b0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    sum[base +: CHUNK] <= s_c;
                    carry_r            <= c_out;
                    if (rem == '0) begin
                        cout      <= c_out;
                        ovf       <= c_msb ^ c_out;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        rem <= rem - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_chunked_adder.sv
// Runs four chunked_adder instances (CHUNK = 4, 1, 8, 16) in lockstep against
// an arithmetic reference built from signed/unsigned integer math.
module tb_chunked_adder;
    localparam int W = 16;
    localparam int NI = 4;
    localparam int CH [NI] = '{4, 1, 8, 16};

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic         cin;
    logic         sub;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         in_ready  [NI];
    logic         out_valid [NI];
    logic         cout      [NI];
    logic         ovf       [NI];
    logic [W-1:0] sum       [NI];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        chunked_adder #(.WIDTH(W), .CHUNK(CH[g])) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready[g]),
            .op_a      (op_a),
            .op_b      (op_b),
            .cin       (cin),
            .sub       (sub),
            .out_valid (out_valid[g]),
            .out_ready (out_ready),
            .sum       (sum[g]),
            .cout      (cout[g]),
            .ovf       (ovf[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_reset(input string tag);
        for (int g = 0; g < NI; g++) begin
            chk($sformatf("%s_in_ready_c%0d", tag, CH[g]), 32'(in_ready[g]), 32'd1);
            chk($sformatf("%s_out_valid_c%0d", tag, CH[g]), 32'(out_valid[g]), 32'd0);
            chk($sformatf("%s_sum_c%0d", tag, CH[g]), 32'(sum[g]), 32'd0);
            chk($sformatf("%s_cout_c%0d", tag, CH[g]), 32'(cout[g]), 32'd0);
            chk($sformatf("%s_ovf_c%0d", tag, CH[g]), 32'(ovf[g]), 32'd0);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input logic s);
        int           sa, sb, sr, ur;
        logic [W-1:0] e_sum;
        logic         e_cout, e_ovf;
        int           lat [NI];
        bit           all_seen;

        sa = int'($signed(a));
        sb = int'($signed(b));
        if (s) begin
            sr     = sa - sb;
            e_sum  = a - b;
            e_cout = (a >= b);
        end else begin
            sr     = sa + sb + int'(ci);
            ur     = int'(a) + int'(b) + int'(ci);
            e_sum  = W'(ur);
            e_cout = (ur > 65535);
        end
        e_ovf = (sr > 32767) || (sr < -32768);

        op_a = a; op_b = b; cin = ci; sub = s; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int g = 0; g < NI; g++) lat[g] = 0;
        all_seen = 1'b0;
        // Operands and in_valid are scrambled while the instances are busy.
        for (int n = 1; n <= 40 && !all_seen; n++) begin
            op_a = W'($urandom); op_b = W'($urandom);
            cin = 1'($urandom); sub = 1'($urandom); in_valid = 1'($urandom);
            @(posedge clk); #1;
            all_seen = 1'b1;
            for (int g = 0; g < NI; g++) begin
                if (lat[g] == 0 && out_valid[g]) lat[g] = n;
                if (lat[g] == 0) all_seen = 1'b0;
            end
        end
        in_valid = 1'b0;
        for (int g = 0; g < NI; g++) begin
            chk($sformatf("latency_c%0d", CH[g]), 32'(lat[g]), 32'(W / CH[g]));
            chk($sformatf("sum_c%0d_%h_%h", CH[g], a, b), 32'(sum[g]), 32'(e_sum));
            chk($sformatf("cout_c%0d_%h_%h", CH[g], a, b), 32'(cout[g]), 32'(e_cout));
            chk($sformatf("ovf_c%0d_%h_%h", CH[g], a, b), 32'(ovf[g]), 32'(e_ovf));
        end
        repeat (3) begin
            @(posedge clk); #1;
            for (int g = 0; g < NI; g++) begin
                chk($sformatf("hold_sum_c%0d", CH[g]), 32'(sum[g]), 32'(e_sum));
                chk($sformatf("hold_flags_c%0d", CH[g]), {30'd0, cout[g], ovf[g]},
                    {30'd0, e_cout, e_ovf});
                chk($sformatf("hold_in_ready_c%0d", CH[g]), 32'(in_ready[g]), 32'd0);
                chk($sformatf("hold_out_valid_c%0d", CH[g]), 32'(out_valid[g]), 32'd1);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int g = 0; g < NI; g++) begin
            chk($sformatf("handoff_out_valid_c%0d", CH[g]), 32'(out_valid[g]), 32'd0);
            chk($sformatf("handoff_in_ready_c%0d", CH[g]), 32'(in_ready[g]), 32'd1);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        cin = 1'b0; sub = 1'b0; op_a = '0; op_b = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_idle_reset("reset");

        run_op(16'h000D, 16'h0003, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        run_op(16'h00FF, 16'h0000, 1'b1, 1'b0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        run_op(16'h8000, 16'h8000, 1'b0, 1'b0);
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1);
        run_op(16'h0009, 16'h0004, 1'b0, 1'b1);
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1);

        // Reset two BUSY edges into an operation: no result may emerge.
        op_a = 16'hABCD; op_b = 16'h1357; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_idle_reset("midop_reset");
        run_op(16'h1234, 16'h4321, 1'b0, 1'b0);

        for (int i = 0; i < 20; i++)
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/chunked_adder.md
Name: chunked_adder

Overview:
- Parametrised, multi-cycle adder/subtractor. Succeeds the team's fixed 4-bit combinational adder.
- Processes WIDTH-bit operands CHUNK bits per clock and carries between chunks in a register, so wide adds close timing at high clock rates.
- Valid/ready handshakes on input and output let it sit between streaming datapath stages.
- Reports sum, carry-out and signed overflow.

Parameters:
- WIDTH, 16, operand and result width in bits. Must be a multiple of CHUNK.
- CHUNK, 4, bits added per clock cycle. 1 <= CHUNK <= WIDTH.

Ports:
- clk        input   1      system clock; all logic on rising edge
- rst        input   1      synchronous reset, active-high
- in_valid   input   1      operands and mode present
- in_ready   output  1      block can accept a new operation
- op_a       input   WIDTH  operand A
- op_b       input   WIDTH  operand B
- cin        input   1      carry-in for add mode; ignored when sub=1
- sub        input   1      0 = A+B+cin, 1 = A-B (A+~B+1)
- out_valid  output  1      result valid
- out_ready  input   1      downstream accepts result
- sum        output  WIDTH  result, modulo 2^WIDTH
- cout       output  1      carry out of MSB (sub: 1 = no borrow)
- ovf        output  1      signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: in_ready=1, out_valid=0, sum=0, cout=0, ovf=0. The FSM goes to IDLE.
- Reset wins over every other input in the same cycle, including mid-operation. Any in-flight operation is discarded with no output.
- NCHUNK = WIDTH/CHUNK.
- FSM states are IDLE, BUSY and DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - An accept occurs on a rising edge with in_valid=1 while in IDLE.
  - On accept, the block captures op_a, op_b (inverted if sub=1) and the initial carry (sub ? 1 : cin).
  - On accept, the chunk counter clears and the state moves to BUSY.
- BUSY:
  - in_ready=0, out_valid=0.
  - Each edge adds chunk k (bits k*CHUNK+CHUNK-1 : k*CHUNK), starting with k=0 (LSB chunk).
  - Each edge writes the partial result into the sum register and updates the carry register.
  - On the final chunk edge (k=NCHUNK-1), the block latches cout and ovf and moves to DONE.
  - ovf uses the carry into bit WIDTH-1, taken from the final chunk's internal carry.
- DONE:
  - out_valid=1, in_ready=0.
  - sum, cout and ovf hold stable while out_ready=0.
  - An edge with out_ready=1 moves to IDLE. out_valid falls and in_ready rises in the next cycle.
  - No accept in the same cycle as result handoff. The minimum issue interval is NCHUNK+2 cycles.
- Latency:
  - out_valid first samples high NCHUNK edges after the accept edge.
  - Example: NCHUNK=4 gives accept at edge 0 and out_valid visible after edge 4.
- Output hold: sum/cout/ovf keep their last values after handoff until the next operation's chunk writes. They are meaningful only while out_valid=1.
- Input capture: op_a, op_b, cin and sub are sampled only at accept. Changes during BUSY/DONE have no effect.
- in_valid while not in IDLE: ignored. The upstream holds its operands until it sees in_ready=1.
- CHUNK=WIDTH: single BUSY cycle, so latency is 1.
- CHUNK=1: fully bit-serial, so latency is WIDTH.
- Arithmetic: result is {cout,sum} = A + B' + c0 with full carry ripple across chunk boundaries. No saturation.

Test Plan:
- Latency and ripple: WIDTH=16, CHUNK=4. Inputs a=0x000D, b=0x0003, cin=0, sub=0. Required: sum=0x0010, cout=0, ovf=0. out_valid rises exactly 4 edges after accept.
- Full ripple: a=0xFFFF, b=0x0001 -> sum=0x0000, cout=1, ovf=0. Separately, a=0x00FF, b=0x0000, cin=1 -> sum=0x0100, cout=0.
- Signed overflow: a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1. Separately, a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
- Subtract: a=0x0005, b=0x0007, sub=1, cin=1 (ignored) -> sum=0xFFFE, cout=0, ovf=0. Separately, a=0x0009, b=0x0004, sub=1 -> sum=0x0005, cout=1.
- Backpressure and input isolation:
  - Hold out_ready=0 for 3 cycles in DONE. Required: sum/cout/ovf stable, in_ready=0.
  - Change op_a/op_b and pulse in_valid during BUSY. Required: result unchanged.
  - Assert out_ready. Required: out_valid=0 and in_ready=1 next cycle.
- Reset mid-operation and param sweep:
  - Assert rst for 1 cycle after 2 BUSY edges. Required: next cycle in_ready=1, out_valid=0, sum=0, cout=0, ovf=0.
  - A following add of 0x1234+0x4321 gives 0x5555.
  - Repeat the arithmetic cases at CHUNK=1, 8 and 16. Required: identical results with latency 16, 2 and 1.
